alu_mc: RTL and testbench
=========================

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter: DATA_WIDTH, 16, operand and result width in bits, legal range 4..64.
REQ-002 Port: Clk  in  1  sole clock; all state updates on rising edge.
REQ-003 Port: Reset_n  in  1  asynchronous, active-low reset.
REQ-004 Port: Op_Valid  in  1  request valid.
REQ-005 Port: Op_Ready  out  1  block can accept a request.
REQ-006 Port: Op_Code  in  2  operation: 00 add, 01 sub, 10 mul, 11 pass.
REQ-007 Port: Reg1_Out  in  DATA_WIDTH  operand 1.
REQ-008 Port: Reg2_Out  in  DATA_WIDTH  operand 2; pass source.
REQ-009 Port: Alu_Valid  out  1  result valid.
REQ-010 Port: Alu_Ready  in  1  consumer accepts result.
REQ-011 Port: Alu_Out  out  DATA_WIDTH  registered result.
REQ-012 Port: Alu_Flags  out  3  {Z,C,V}; exists only with ALU_MC_FLAGS_EN.

Function
REQ-013 The FSM SHALL have states IDLE, MUL, DONE.
REQ-014 Op_Ready SHALL be 1 only in IDLE; a request SHALL be accepted on a cycle with Op_Valid=1 and Op_Ready=1.
REQ-015 Operands and Op_Code SHALL be captured at acceptance; later input changes SHALL be ignored until the next acceptance.
REQ-016 Add, sub and pass SHALL go IDLE->DONE with Alu_Valid=1 on the cycle after acceptance (latency 1).
REQ-017 Mul SHALL go IDLE->MUL and iterate shift-add, one multiplier bit per cycle for DATA_WIDTH cycles, then go to DONE (latency DATA_WIDTH+1).
REQ-018 Add, sub and mul results SHALL be truncated to the low DATA_WIDTH bits (wrap modulo 2^DATA_WIDTH); pass SHALL output Reg2_Out.
REQ-019 In DONE, Alu_Valid SHALL be 1 and Alu_Out/Alu_Flags SHALL hold stable while Alu_Ready=0.
REQ-020 DONE->IDLE SHALL occur on a cycle with Alu_Valid=1 and Alu_Ready=1; no new request SHALL be accepted in that same cycle.
REQ-021 Op_Valid asserted in MUL or DONE SHALL have no effect.
REQ-022 Alu_Out SHALL retain the last result after returning to IDLE; Alu_Valid SHALL be 0 outside DONE.

Reset
REQ-023 While Reset_n=0: state IDLE, Op_Ready=1, Alu_Valid=0, Alu_Out=0, Alu_Flags=000, multiplier registers cleared.
REQ-024 Reset asserted in MUL or DONE SHALL abort the operation immediately with no result delivered.

Configuration
REQ-025 With ALU_MC_FLAGS_EN defined, Alu_Flags SHALL be registered with Alu_Out: Z = result==0; C = add carry-out, sub borrow (Reg1<Reg2 unsigned), mul any nonzero discarded upper product bit, 0 for pass; V = signed overflow for add/sub, else 0.
REQ-026 Without ALU_MC_FLAGS_EN, the Alu_Flags port and all flag logic SHALL be absent; other behaviour SHALL be unchanged.

Structure
REQ-027 Opcode constants (ALU_OP_ADD/SUB/MUL/PASS) and the FSM state encoding SHALL live in the shared package/include alongside DATA_WIDTH.
REQ-028 The iterative multiplier SHALL be a sub-module alu_mul_iter (start, operands, done, product) instantiated once.

Verification (DATA_WIDTH=8)
REQ-029 Add 200+100 -> Alu_Valid 1 cycle after accept, Alu_Out=44, flags Z0 C1 V0.
REQ-030 Sub 5-7 -> Alu_Out=254, C1 V0; sub 128-1 -> 127, V1.
REQ-031 Mul 13*11 -> Alu_Out=143 exactly 9 cycles after accept, C0; mul 20*20 -> 144, C1.
REQ-032 Pass with Alu_Ready held 0 for 5 cycles -> Alu_Valid and Alu_Out stable, Op_Ready 0, new Op_Valid ignored; Alu_Ready=1 -> IDLE next cycle.
REQ-033 Reset_n low 4 cycles into mul 255*255 -> Alu_Valid 0, Alu_Out 0, Op_Ready 1 immediately; next add 1+1 -> 2.

Source files
------------

// File: rtl/alu_mc_pkg.sv
// Shared constants for the multi-cycle ALU: default width, opcodes, FSM states.
// The optional {Z,C,V} flag output is built only when ALU_MC_FLAGS_EN is defined.
package alu_mc_pkg;

  localparam int ALU_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    ALU_OP_ADD  = 2'b00,
    ALU_OP_SUB  = 2'b01,
    ALU_OP_MUL  = 2'b10,
    ALU_OP_PASS = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DONE = 2'b10
  } alu_state_e;

endpackage

// File: rtl/alu_mc_if.sv
// Request/result handshake bundle for alu_mc; Alu_Flags exists only with ALU_MC_FLAGS_EN.
interface alu_mc_if import alu_mc_pkg::*; #(
  parameter int DATA_WIDTH = ALU_DATA_WIDTH
);
  logic                  Op_Valid;
  logic                  Op_Ready;
  logic [1:0]            Op_Code;
  logic [DATA_WIDTH-1:0] Reg1_Out;
  logic [DATA_WIDTH-1:0] Reg2_Out;
  logic                  Alu_Valid;
  logic                  Alu_Ready;
  logic [DATA_WIDTH-1:0] Alu_Out;
`ifdef ALU_MC_FLAGS_EN
  logic [2:0]            Alu_Flags;
`endif

  modport slave (
    input  Op_Valid, Op_Code, Reg1_Out, Reg2_Out, Alu_Ready,
    output Op_Ready, Alu_Valid, Alu_Out
`ifdef ALU_MC_FLAGS_EN
    , output Alu_Flags
`endif
  );

  modport master (
    output Op_Valid, Op_Code, Reg1_Out, Reg2_Out, Alu_Ready,
    input  Op_Ready, Alu_Valid, Alu_Out
`ifdef ALU_MC_FLAGS_EN
    , input Alu_Flags
`endif
  );
endinterface

// File: rtl/alu_mc_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle for DATA_WIDTH cycles.
// product/done are the combinational result of the final step; ovf only with ALU_MC_FLAGS_EN.
module alu_mul_iter import alu_mc_pkg::*; #(
  parameter int DATA_WIDTH = ALU_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  done,
`ifdef ALU_MC_FLAGS_EN
  output logic                  ovf,
`endif
  output logic [DATA_WIDTH-1:0] product
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  // acc upper half: partial sum; lower half: remaining multiplier bits
  logic [2*W-1:0] acc;
  logic [2*W-1:0] acc_nxt;
  logic [W-1:0]   mcand;
  logic [W:0]     sum;
  logic [CW-1:0]  cnt;
  logic           busy;

  assign sum     = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, mcand} : {(W+1){1'b0}});
  assign acc_nxt = {sum, acc[W-1:1]};
  assign done    = busy && (cnt == CW'(W-1));
  assign product = acc_nxt[W-1:0];
`ifdef ALU_MC_FLAGS_EN
  assign ovf     = |acc_nxt[2*W-1:W];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      mcand <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
    end else if (start) begin
      acc   <= {{W{1'b0}}, b};
      mcand <= a;
      cnt   <= '0;
      busy  <= 1'b1;
    end else if (busy) begin
      acc <= acc_nxt;
      cnt <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end
endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: add/sub/pass in one cycle, shift-add mul in DATA_WIDTH+1 cycles.
// Define ALU_MC_FLAGS_EN to add the registered {Z,C,V} flag output.
module alu_mc import alu_mc_pkg::*; #(
  parameter int DATA_WIDTH = ALU_DATA_WIDTH
) (
  input  logic        Clk,
  input  logic        Reset_n,
  alu_mc_if.slave     alu
);
  localparam int W = DATA_WIDTH;

  alu_state_e   state;
  alu_op_e      op;
  logic         op_ready;
  logic         alu_valid;
  logic [W-1:0] alu_out;
  logic [W-1:0] a, b;
  logic [W:0]   add_full, sub_full;
  logic [W-1:0] fast_res;
  logic         mul_start, mul_done;
  logic [W-1:0] mul_prod;

  assign op       = alu_op_e'(alu.Op_Code);
  assign a        = alu.Reg1_Out;
  assign b        = alu.Reg2_Out;
  assign add_full = {1'b0, a} + {1'b0, b};
  assign sub_full = {1'b0, a} - {1'b0, b};

  always_comb begin
    fast_res = b;
    case (op)
      ALU_OP_ADD: fast_res = add_full[W-1:0];
      ALU_OP_SUB: fast_res = sub_full[W-1:0];
      default:    fast_res = b;
    endcase
  end

  // Operands go straight into the multiplier on the accept edge
  assign mul_start = (state == ST_IDLE) && alu.Op_Valid && (op == ALU_OP_MUL);

`ifdef ALU_MC_FLAGS_EN
  logic       mul_ovf;
  logic [2:0] flags;
  logic [2:0] fast_flags;

  always_comb begin
    fast_flags = 3'b000;
    case (op)
      ALU_OP_ADD: fast_flags = {add_full[W-1:0] == '0, add_full[W],
                                (a[W-1] == b[W-1]) && (add_full[W-1] != a[W-1])};
      ALU_OP_SUB: fast_flags = {sub_full[W-1:0] == '0, sub_full[W],
                                (a[W-1] != b[W-1]) && (sub_full[W-1] != a[W-1])};
      default:    fast_flags = {b == '0, 2'b00};
    endcase
  end

  assign alu.Alu_Flags = flags;
`endif

  alu_mul_iter #(.DATA_WIDTH(W)) u_mul (
    .clk     (Clk),
    .rst_n   (Reset_n),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
`ifdef ALU_MC_FLAGS_EN
    .ovf     (mul_ovf),
`endif
    .product (mul_prod)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= ST_IDLE;
      op_ready  <= 1'b1;
      alu_valid <= 1'b0;
      alu_out   <= '0;
`ifdef ALU_MC_FLAGS_EN
      flags     <= 3'b000;
`endif
    end else begin
      case (state)
        ST_IDLE: if (alu.Op_Valid) begin
          op_ready <= 1'b0;
          if (op == ALU_OP_MUL) begin
            state <= ST_MUL;
          end else begin
            state     <= ST_DONE;
            alu_valid <= 1'b1;
            alu_out   <= fast_res;
`ifdef ALU_MC_FLAGS_EN
            flags     <= fast_flags;
`endif
          end
        end
        ST_MUL: if (mul_done) begin
          state     <= ST_DONE;
          alu_valid <= 1'b1;
          alu_out   <= mul_prod;
`ifdef ALU_MC_FLAGS_EN
          flags     <= {mul_prod == '0, mul_ovf, 1'b0};
`endif
        end
        // Ready only returns on the edge after the handshake, so no back-to-back accept
        ST_DONE: if (alu.Alu_Ready) begin
          state     <= ST_IDLE;
          alu_valid <= 1'b0;
          op_ready  <= 1'b1;
        end
        default: begin
          state     <= ST_IDLE;
          alu_valid <= 1'b0;
          op_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign alu.Op_Ready  = op_ready;
  assign alu.Alu_Valid = alu_valid;
  assign alu.Alu_Out   = alu_out;
endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc at DATA_WIDTH=8; flag checks compile in with ALU_MC_FLAGS_EN.
module tb_alu_mc;
  import alu_mc_pkg::*;

  typedef struct {
    logic [7:0] out;
    logic [2:0] flg;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_chk = 0;
  int   n_bad = 0;
  exp_t sb[$];

  alu_mc_if #(.DATA_WIDTH(8)) bus ();

  alu_mc #(.DATA_WIDTH(8)) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .alu     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Independent reference: integer arithmetic, flags {Z,C,V}
  function automatic exp_t model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int s, sa, sb2, sv;
    logic c, v;
    sa = $signed(a);
    sb2 = $signed(b);
    c = 1'b0;
    v = 1'b0;
    case (op)
      2'd0: begin s = int'(a) + int'(b); sv = sa + sb2; c = s > 255; v = (sv > 127) || (sv < -128); end
      2'd1: begin s = int'(a) - int'(b); sv = sa - sb2; c = a < b;   v = (sv > 127) || (sv < -128); end
      2'd2: begin s = int'(a) * int'(b); c = s > 255; end
      default: s = int'(b);
    endcase
    e.out = s[7:0];
    e.flg = {e.out == 8'd0, c, v};
    return e;
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && bus.Alu_Valid && bus.Alu_Ready) begin
      if (sb.size() == 0) chk("sb_underflow", sb.size(), 1);
      else begin
        e = sb.pop_front();
        chk("alu_out", bus.Alu_Out, e.out);
`ifdef ALU_MC_FLAGS_EN
        chk("alu_flags", bus.Alu_Flags, e.flg);
`endif
      end
    end
  end

  // Entered just after a posedge with the DUT idle; leaves it idle the same way
  task automatic do_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] eo, input logic [2:0] ef, input int hold);
    int n;
    exp_t e;
    logic [7:0] held;
    bus.Op_Valid = 1'b1; bus.Op_Code = op; bus.Reg1_Out = a; bus.Reg2_Out = b;
    bus.Alu_Ready = 1'b0;
    @(negedge clk);
    chk("op_ready_idle", bus.Op_Ready, 1);
    @(posedge clk);
    e.out = eo; e.flg = ef;
    sb.push_back(e);
    #1;
    // Keep Op_Valid up with fresh junk: must be ignored in MUL/DONE
    bus.Op_Code = 2'($urandom_range(3));
    bus.Reg1_Out = 8'($urandom_range(255));
    bus.Reg2_Out = 8'($urandom_range(255));
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!bus.Alu_Valid && n > 1) chk("op_ready_busy", bus.Op_Ready, 0);
    end while (!bus.Alu_Valid && n < 200);
    chk("latency", n, (op == 2'd2) ? 9 : 1);
    held = bus.Alu_Out;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("hold_valid", bus.Alu_Valid, 1);
      chk("hold_out", bus.Alu_Out, held);
      chk("hold_ready", bus.Op_Ready, 0);
    end
    @(posedge clk); #1;
    bus.Op_Valid = 1'b0;
    bus.Alu_Ready = 1'b1;
    @(posedge clk); #1;
    bus.Alu_Ready = 1'b0;
    @(negedge clk);
    chk("post_valid", bus.Alu_Valid, 0);
    chk("post_ready", bus.Op_Ready, 1);
    chk("post_retain", bus.Alu_Out, held);
    @(posedge clk); #1;
  endtask

  initial begin
    int seen;
    exp_t m;
    logic [1:0] rop;
    logic [7:0] ra, rb;
    rst_n = 1'b0;
    bus.Op_Valid = 1'b0; bus.Op_Code = 2'd0; bus.Reg1_Out = 8'd0; bus.Reg2_Out = 8'd0;
    bus.Alu_Ready = 1'b0;
    #12;
    chk("rst_ready", bus.Op_Ready, 1);
    chk("rst_valid", bus.Alu_Valid, 0);
    chk("rst_out", bus.Alu_Out, 0);
`ifdef ALU_MC_FLAGS_EN
    chk("rst_flags", bus.Alu_Flags, 0);
`endif
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(2'd0, 8'd200, 8'd100, 8'd44,  3'b010, 0);
    do_op(2'd1, 8'd5,   8'd7,   8'd254, 3'b010, 0);
    do_op(2'd1, 8'd128, 8'd1,   8'd127, 3'b001, 1);
    do_op(2'd2, 8'd13,  8'd11,  8'd143, 3'b000, 0);
    do_op(2'd2, 8'd20,  8'd20,  8'd144, 3'b010, 2);
    do_op(2'd3, 8'd7,   8'h5A,  8'h5A,  3'b000, 5);
    do_op(2'd0, 8'd128, 8'd128, 8'd0,   3'b111, 0);
    do_op(2'd3, 8'd9,   8'd0,   8'd0,   3'b100, 0);
    do_op(2'd2, 8'd255, 8'd255, 8'd1,   3'b010, 0);
    do_op(2'd2, 8'd0,   8'd77,  8'd0,   3'b100, 0);

    // Abort a multiply with reset four cycles in
    bus.Op_Valid = 1'b1; bus.Op_Code = 2'd2; bus.Reg1_Out = 8'd255; bus.Reg2_Out = 8'd255;
    @(posedge clk); #1;
    bus.Op_Valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", bus.Alu_Valid, 0);
    chk("abort_out", bus.Alu_Out, 0);
    chk("abort_ready", bus.Op_Ready, 1);
`ifdef ALU_MC_FLAGS_EN
    chk("abort_flags", bus.Alu_Flags, 0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.Alu_Valid) seen++;
    end
    chk("abort_no_result", seen, 0);
    @(posedge clk); #1;
    do_op(2'd0, 8'd1, 8'd1, 8'd2, 3'b000, 0);

    for (int i = 0; i < 20; i++) begin
      rop = 2'($urandom_range(3));
      ra = 8'($urandom_range(255));
      rb = 8'($urandom_range(255));
      m = model(rop, ra, rb);
      do_op(rop, ra, rb, m.out, m.flg, int'($urandom_range(2)));
    end

    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
